// File: rtl/mtr_drv_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_mc_if
// Purpose  : Controller <-> motor PWM driver bundle (enable, speeds, PWM pins).
//            Monitor signals exist only when MTR_DRV_MON_EN is defined.
// Revision : 1.0
// ============================================================================
interface mtr_drv_mc_if #(
    parameter int NUM_CH = 2,
    parameter int PWM_W  = 11
);
    logic                      en_i;
    logic [NUM_CH*PWM_W-1:0]   spd_i;
    logic [NUM_CH-1:0]         pwm1_o;
    logic [NUM_CH-1:0]         pwm2_o;
    logic                      prd_strb_o;
`ifdef MTR_DRV_MON_EN
    logic [NUM_CH*PWM_W-1:0]   duty_mon_o;
    logic [NUM_CH-1:0]         settled_o;
`endif

    modport master (
        output en_i, spd_i,
`ifdef MTR_DRV_MON_EN
        input  duty_mon_o, settled_o,
`endif
        input  pwm1_o, pwm2_o, prd_strb_o
    );

    modport slave (
        input  en_i, spd_i,
`ifdef MTR_DRV_MON_EN
        output duty_mon_o, settled_o,
`endif
        output pwm1_o, pwm2_o, prd_strb_o
    );
endinterface
`default_nettype wire

// File: rtl/mtr_drv_mc.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_mc
// Purpose  : N-channel H-bridge PWM driver: signed speed -> offset-binary duty,
//            period-synchronous slew-limited update, dead-time insertion.
//            Define MTR_DRV_MON_EN to add duty_mon/settled monitor outputs.
// Revision : 1.0
// ============================================================================
module mtr_drv_mc #(
    parameter int NUM_CH    = 2,
    parameter int PWM_W     = 11,
    parameter int DEADTIME  = 4,
    parameter int SLEW_STEP = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    mtr_drv_mc_if.slave   bus
);
    localparam int               DT_W    = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [DT_W-1:0]  DT_MAX  = DT_W'(DEADTIME);
    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] CNT_PRE = CNT_MAX - PWM_W'(1);
    localparam logic [PWM_W-1:0] MID     = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W-1:0] STEP_N  = PWM_W'(SLEW_STEP);
    localparam logic [PWM_W:0]   STEP_X  = (PWM_W+1)'(SLEW_STEP);

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;
    logic             prd_strb_q;
    logic             period_end;

    assign cnt_d      = cnt_q + PWM_W'(1);
    assign period_end = (cnt_q == CNT_MAX);

    // Strobe is registered one count early so it lines up with cnt == max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            prd_strb_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prd_strb_q <= (cnt_q == CNT_PRE);
        end
    end

    assign bus.prd_strb_o = prd_strb_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PWM_W-1:0] tgt;
        logic [PWM_W-1:0] duty_q;
        logic [PWM_W-1:0] duty_d;
        logic [PWM_W:0]   tgt_x;
        logic [PWM_W:0]   duty_x;
        logic             raw;
        logic [DT_W-1:0]  dt1_q;
        logic [DT_W-1:0]  dt2_q;
        logic             pwm1_q;
        logic             pwm2_q;

        assign tgt    = bus.spd_i[i*PWM_W +: PWM_W] ^ MID;
        assign tgt_x  = {1'b0, tgt};
        assign duty_x = {1'b0, duty_q};
        assign raw    = (cnt_q < duty_q);

        // Compared one bit wider so duty +/- step can neither wrap nor overshoot.
        always_comb begin
            duty_d = tgt;
            if (SLEW_STEP != 0) begin
                if (tgt_x > duty_x + STEP_X) begin
                    duty_d = duty_q + STEP_N;
                end else if (tgt_x + STEP_X < duty_x) begin
                    duty_d = duty_q - STEP_N;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_q <= MID;
                dt1_q  <= '0;
                dt2_q  <= '0;
                pwm1_q <= 1'b0;
                pwm2_q <= 1'b0;
            end else if (!bus.en_i) begin
                duty_q <= MID;
                dt1_q  <= '0;
                dt2_q  <= '0;
                pwm1_q <= 1'b0;
                pwm2_q <= 1'b0;
            end else begin
                if (period_end) begin
                    duty_q <= duty_d;
                end
                // Each side needs DEADTIME+1 consecutive samples before driving.
                if (raw) begin
                    pwm2_q <= 1'b0;
                    dt2_q  <= '0;
                    if (dt1_q == DT_MAX) begin
                        pwm1_q <= 1'b1;
                    end else begin
                        dt1_q <= dt1_q + DT_W'(1);
                    end
                end else begin
                    pwm1_q <= 1'b0;
                    dt1_q  <= '0;
                    if (dt2_q == DT_MAX) begin
                        pwm2_q <= 1'b1;
                    end else begin
                        dt2_q <= dt2_q + DT_W'(1);
                    end
                end
            end
        end

        assign bus.pwm1_o[i] = pwm1_q;
        assign bus.pwm2_o[i] = pwm2_q;

`ifdef MTR_DRV_MON_EN
        logic settled_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                settled_q <= 1'b0;
            end else begin
                settled_q <= (duty_q == tgt);
            end
        end

        assign bus.duty_mon_o[i*PWM_W +: PWM_W] = duty_q;
        assign bus.settled_o[i]                 = settled_q;
`endif
    end
endmodule
`default_nettype wire

// File: tb/tb_mtr_drv_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtr_drv_mc
// Purpose  : Directed self-checking bench for mtr_drv_mc; per-period PWM high
//            counts are predicted into a scoreboard and compared at each strobe.
// Revision : 1.0
// ============================================================================
module tb_mtr_drv_mc;
    localparam int NUM_CH = 2;
    localparam int PWM_W  = 11;
    localparam int PER    = 2048;
    localparam int MIDV   = 1024;
    localparam int STEP   = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mtr_drv_mc_if #(.NUM_CH(NUM_CH), .PWM_W(PWM_W)) bus ();

    mtr_drv_mc #(
        .NUM_CH   (NUM_CH),
        .PWM_W    (PWM_W),
        .DEADTIME (4),
        .SLEW_STEP(STEP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string tag;
        int    ch;
        int    p1;
        int    p2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   nper  = 0;
    int   acc1[NUM_CH];
    int   acc2[NUM_CH];
    int   done1[NUM_CH];
    int   done2[NUM_CH];
    int   tgt[NUM_CH];
    int   dp[NUM_CH];
    int   dn[NUM_CH];
    bit   cy[NUM_CH];

    // Window = one full period; closes on the cycle that carries prd_strb.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc1[c] = 0;
                acc2[c] = 0;
            end
        end else begin
            total++;
            assert ((bus.pwm1_o & bus.pwm2_o) === 2'b00) else begin
                bad++;
                $error("FAIL overlap: pwm1=%b pwm2=%b required no common bit", bus.pwm1_o, bus.pwm2_o);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                acc1[c] += int'(bus.pwm1_o[c]);
                acc2[c] += int'(bus.pwm2_o[c]);
            end
            if (bus.prd_strb_o) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    done1[c] = acc1[c];
                    done2[c] = acc2[c];
                    acc1[c]  = 0;
                    acc2[c]  = 0;
                end
                nper++;
            end
        end
    end

    function automatic int slew(int t, int d);
        if (t > d + STEP) return d + STEP;
        if (t < d - STEP) return d - STEP;
        return t;
    endfunction

    function automatic int exp_p1(int d);
        return (d >= 5) ? d - 4 : 0;
    endfunction

    // carry: pwm2 was already high when the window opened.
    function automatic int exp_p2(int d, bit carry);
        if (d == 0) return carry ? PER : PER - 5;
        return (carry ? 1 : 0) + ((d <= PER - 5) ? PER - 5 - d : 0);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_spd(int c, int s);
        bus.spd_i[c*PWM_W +: PWM_W] = PWM_W'(s);
        tgt[c] = s + MIDV;
    endtask

    task automatic push_win(string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_t e;
            e.tag = $sformatf("%s_ch%0d", tag, c);
            e.ch  = c;
            e.p1  = exp_p1(dn[c]);
            e.p2  = exp_p2(dn[c], cy[c]);
            sb.push_back(e);
        end
    endtask

    task automatic push_raw(string tag, int p1, int p2);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_t e;
            e.tag = $sformatf("%s_ch%0d", tag, c);
            e.ch  = c;
            e.p1  = p1;
            e.p2  = p2;
            sb.push_back(e);
        end
    endtask

    task automatic wait_period();
        int start = nper;
        bit seen  = 1'b0;
        for (int i = 0; i < PER + 64 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (nper != start);
        end
        total++;
        assert (seen === 1'b1) else begin
            bad++;
            $error("FAIL period_timeout: got=0 exp=1");
        end
    endtask

    task automatic pop_check();
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            check({e.tag, "_p1"}, done1[e.ch], e.p1);
            check({e.tag, "_p2"}, done2[e.ch], e.p2);
        end
    endtask

    // Steady window: duty unchanged, so carry depends on the previous duty.
    task automatic plan_next();
        for (int c = 0; c < NUM_CH; c++) begin
            cy[c] = (dp[c] <= PER - 5);
            dn[c] = slew(tgt[c], dp[c]);
        end
    endtask

    task automatic commit();
        for (int c = 0; c < NUM_CH; c++) dp[c] = dn[c];
    endtask

    initial begin
        bus.en_i  = 1'b0;
        bus.spd_i = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tgt[c] = MIDV;
            dp[c]  = MIDV;
        end

        repeat (3) @(negedge clk);
        #1;
        check("rst_pwm1", bus.pwm1_o, 0);
        check("rst_pwm2", bus.pwm2_o, 0);
        check("rst_strb", bus.prd_strb_o, 0);

        rst_n    = 1'b1;
        bus.en_i = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        check("run_pwm1", bus.pwm1_o, 2'b11);
        check("run_pwm2", bus.pwm2_o, 2'b00);

        #2 rst_n = 1'b0;
        #1;
        check("async_pwm1", bus.pwm1_o, 0);
        check("async_pwm2", bus.pwm2_o, 0);
        check("async_strb", bus.prd_strb_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2046) @(posedge clk);
        #1;
        check("strb_early", bus.prd_strb_o, 0);
        @(posedge clk);
        #1;
        check("strb_first", bus.prd_strb_o, 1);

        // First window after release: pwm2 starts from idle, no carry-in.
        for (int c = 0; c < NUM_CH; c++) begin
            dn[c] = MIDV;
            cy[c] = 1'b0;
        end
        push_win("zero_first");
        wait_period();
        pop_check();

        plan_next();
        push_win("zero_steady");
        wait_period();
        pop_check();
        commit();

        set_spd(0, 1023);
        set_spd(1, -1021);
        for (int k = 1; k <= 16; k++) begin
            plan_next();
            push_win($sformatf("ramp%0d", k));
            wait_period();
            pop_check();
`ifdef MTR_DRV_MON_EN
            for (int c = 0; c < NUM_CH; c++) begin
                check($sformatf("mon_duty%0d_ch%0d", k, c), bus.duty_mon_o[c*PWM_W +: PWM_W], dn[c]);
                check($sformatf("mon_settled%0d_ch%0d", k, c), bus.settled_o[c], (dn[c] == tgt[c]) ? 1 : 0);
            end
`endif
            commit();
        end

        plan_next();
        push_win("hold_max_short");
        wait_period();
        pop_check();
        commit();

        set_spd(1, -1024);
        for (int k = 0; k < 2; k++) begin
            plan_next();
            push_win($sformatf("reverse%0d", k));
            wait_period();
            pop_check();
            commit();
        end

        repeat (500) @(posedge clk);
        #1;
        check("precoast_pwm1", bus.pwm1_o, 2'b01);
        check("precoast_pwm2", bus.pwm2_o, 2'b10);
        bus.en_i = 1'b0;
        @(posedge clk);
        #1;
        check("coast_pwm1", bus.pwm1_o, 0);
        check("coast_pwm2", bus.pwm2_o, 0);
`ifdef MTR_DRV_MON_EN
        check("coast_duty_ch0", bus.duty_mon_o[0 +: PWM_W], MIDV);
        check("coast_duty_ch1", bus.duty_mon_o[PWM_W +: PWM_W], MIDV);
`endif
        repeat (200) @(posedge clk);
        #1;
        check("coast_hold", {bus.pwm1_o, bus.pwm2_o}, 0);
        wait_period();

        push_raw("coast_full", 0, 0);
        wait_period();
        pop_check();

        // Re-enable on the boundary cycle: that edge must already update duty.
        bus.en_i = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            dp[c] = MIDV;
            dn[c] = slew(tgt[c], MIDV);
            cy[c] = 1'b0;
        end
        push_win("reenable");
        wait_period();
        pop_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
